rr_sel_arbiter_8ch: RTL and testbench

Eight-channel round-robin arbiter that produces the 3-bit select (s2,s1,s0) and data-valid for the 8:1 mux stage directly downstream. Requesters raise a request line; the arbiter grants one channel at a time, holds the select stable for the whole transfer, and rotates priority so no channel starves. A programmable hold limit forces release of a channel that never signals completion.

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_sel_arbiter_8ch_pick.sv | 41 ++++
 rtl/rr_sel_arbiter_8ch.sv | 126 ++++++++++++
 tb/tb_rr_sel_arbiter_8ch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-channel round-robin select arbiter.
package arb_pkg;

  localparam int N_CH   = 8;  // number of requesting channels / mux inputs
  localparam int SEL_W  = 3;  // width of the mux select {s2,s1,s0}
  localparam int HOLD_W = 8;  // width of the grant hold counter (MAX_HOLD <= 255)

  // Arbiter control state; exported on the debug port of the top.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_sel_arbiter_8ch_pick.sv
// Round-robin pick: rotate requests so the channel after ptr sits at bit 0,
// take the lowest set bit, then map that offset back to a channel index.
import arb_pkg::*;

module rr_pick (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any_req
);

  logic [3:0]          start;
  logic [2*N_CH-1:0]   dbl;
  logic [2*N_CH-1:0]   shifted;
  logic [N_CH-1:0]     rot;
  logic [SEL_W-1:0]    off;
  logic                found;

  // Rotate by ptr+1 (1..8) using a doubled vector so wrap 7->0 is automatic.
  always_comb begin
    start   = {1'b0, ptr} + 4'd1;
    dbl     = {req, req};
    shifted = dbl >> start;
    rot     = shifted[N_CH-1:0];
  end

  // Lowest set bit of the rotated vector, then un-rotate with a 3-bit add.
  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (!found && rot[k]) begin
        off   = SEL_W'(k);
        found = 1'b1;
      end
    end
    any_req = |req;
    pick    = start[SEL_W-1:0] + off;
  end

endmodule

// File: rtl/rr_sel_arbiter_8ch.sv
// Eight-channel round-robin arbiter driving the select and data-valid of a
// downstream 8:1 mux. One grant at a time, select frozen for the whole
// transfer, forced release after MAX_HOLD cycles.
//
// Handshake: a channel is granted while valid=1 and gnt[sel]=1. The transfer
// ends when the granted channel pulses done, drops its req, or the hold limit
// is reached; outputs clear on the following edge and at least one idle cycle
// separates consecutive grants. done is only honoured while a grant is active.
import arb_pkg::*;

module rr_sel_arbiter_8ch #(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            done,
  output logic [N_CH-1:0] gnt,
  output logic            s2,
  output logic            s1,
  output logic            s0,
  output logic            valid,
  output logic            timeout,
  output arb_state_e      dbg_state
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_CH-1:0]   gnt_q, gnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;

  logic [SEL_W-1:0]  pick;
  logic              any_req;
  logic              rel_done, rel_drop, rel_limit;

  rr_pick u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .pick    (pick),
    .any_req (any_req)
  );

  // Release causes for the channel currently holding the grant.
  always_comb begin
    rel_done  = done;
    rel_drop  = ~req[sel_q];
    rel_limit = (hold_q == MAX_HOLD_C);
  end

  // Next-state and next-output logic; everything defaults to "hold".
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d   = N_CH'(1) << pick;
          sel_d   = pick;
          valid_d = 1'b1;
          hold_d  = HOLD_W'(1);
          state_d = ST_GRANT;
        end else begin
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (rel_done || rel_drop || rel_limit) begin
          gnt_d     = '0;
          valid_d   = 1'b0;
          ptr_d     = sel_q;
          state_d   = ST_IDLE;
          // done wins over the hold limit when both land in one cycle.
          timeout_d = rel_limit && !rel_done && !rel_drop;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset restarts arbitration at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= SEL_W'(N_CH - 1);
      hold_q    <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign s2        = sel_q[2];
  assign s1        = sel_q[1];
  assign s0        = sel_q[0];
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_sel_arbiter_8ch.sv
// Bench for rr_sel_arbiter_8ch: directed scenarios plus random traffic,
// every cycle compared against a transaction-level arbiter model.
import arb_pkg::*;

module tb_rr_sel_arbiter_8ch;

  localparam int MAXH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] req  = '0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic       s2, s1, s0, valid, timeout;
  arb_state_e dbg_state;

  rr_sel_arbiter_8ch #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .s2        (s2),
    .s1        (s1),
    .s0        (s0),
    .valid     (valid),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  logic [2:0] sel;
  assign sel = {s2, s1, s0};

  // ---------------- scoreboard / checker ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks who owns the bus, for how long, and who was served last.
  bit      m_busy;
  int      m_ch;
  int      m_len;
  int      m_last;
  int      m_sel;
  bit      m_to;

  function automatic int rr_next(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      if (r[(last + k) % 8]) return (last + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_ch = 0; m_len = 0; m_last = 7; m_sel = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (!m_busy) begin
        if (req != 0) begin
          m_ch   = rr_next(req, m_last);
          m_sel  = m_ch;
          m_busy = 1;
          m_len  = 1;
        end
      end else if (done || !req[m_ch] || m_len == MAXH) begin
        m_to   = !done && req[m_ch] && (m_len == MAXH);
        m_busy = 0;
        m_last = m_ch;
      end else begin
        m_len++;
      end
    end
  end

  // Per-cycle comparison away from the active edge.
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check_eq("gnt",     gnt,     m_busy ? (32'd1 << m_ch) : 32'd0);
      check_eq("sel",     sel,     m_sel);
      check_eq("valid",   valid,   m_busy);
      check_eq("timeout", timeout, m_to);
      check_eq("state",   dbg_state, m_busy);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (valid) ok = 1;
    end
    if (!ok) check_eq("wait_valid", 0, 1);
  endtask

  task automatic expect_grant();
    logic [2:0] e;
    bit ok;
    wait_valid(ok);
    if (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("order_sel", sel, e);
      check_eq("order_gnt", gnt, 32'd1 << e);
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int cnt;

    // Reset state, checked without any clock edge having occurred.
    #1;
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_timeout", timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1;

    // Single requester, completion after four valid cycles.
    @(negedge clk);
    req = 8'h01;
    exp_q.push_back(3'd0);
    expect_grant();
    repeat (3) @(negedge clk);
    check_eq("single_valid4", valid, 1);
    pulse_done();
    check_eq("single_rel", valid, 0);
    req = 8'h00;
    repeat (2) @(negedge clk);

    // All requesting, done every grant: strict rotation 0..7,0.
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) exp_q.push_back(3'(i % 8));
    for (int i = 0; i < 9; i++) begin
      expect_grant();
      pulse_done();
      check_eq("ff_gap_idle", valid, 0);
    end
    req = 8'h00;
    @(negedge clk);
    @(negedge clk);

    // Channel 3 served, then 3 and 0 request: wrap picks 0.
    req = 8'h08;
    exp_q.push_back(3'd3);
    expect_grant();
    pulse_done();
    req = 8'h09;
    exp_q.push_back(3'd0);
    expect_grant();
    pulse_done();
    req = 8'h00;
    repeat (2) @(negedge clk);

    // Channel 5 never completes: forced release after MAXH cycles.
    req = 8'h20;
    exp_q.push_back(3'd5);
    expect_grant();
    req = 8'h21;
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!valid) break;
      cnt++;
    end
    check_eq("to_len", cnt, MAXH);
    check_eq("to_pulse", timeout, 1);
    exp_q.push_back(3'd0);
    expect_grant();
    check_eq("to_pulse_once", timeout, 0);
    pulse_done();
    req = 8'h00;
    repeat (2) @(negedge clk);

    // done coincides with the hold limit: no timeout.
    req = 8'h04;
    exp_q.push_back(3'd2);
    expect_grant();
    repeat (MAXH - 1) @(negedge clk);
    pulse_done();
    check_eq("done_lim_valid", valid, 0);
    check_eq("done_lim_to", timeout, 0);
    req = 8'h00;
    repeat (2) @(negedge clk);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
      done = ($urandom_range(0, 5) == 0);
    end
    done = 1'b0;
    req = 8'h00;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a channel-6 grant.
    req = 8'h40;
    exp_q.push_back(3'd6);
    expect_grant();
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_gnt", gnt, 0);
    check_eq("arst_valid", valid, 0);
    check_eq("arst_sel", sel, 0);
    @(negedge clk);
    rst = 1'b0;
    req = 8'hC1;
    exp_q.push_back(3'd0);
    expect_grant();
    pulse_done();
    req = 8'h00;
    repeat (3) @(negedge clk);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
